rgmii_rx_mode_adapter: RTL and testbench
========================================

RGMII_RX_MODE_ADAPTER -- requirements
Module: rgmii_rx_mode_adapter

Interface
REQ-001 Parameter STATUS_FILTER, default 4, SHALL set the number of consecutive identical in-band status samples (range 1-255) required before status outputs update.
REQ-002 Parameter ERR_COUNT_WIDTH, default 16, SHALL set the width of the saturating alignment-error counter.
REQ-003 Port clk  in  1  SHALL be the RX clock; all logic SHALL be single-clock, rising-edge.
REQ-004 Port rst_n  in  1  SHALL be an asynchronous active-low reset.
REQ-005 Port speed  in  2  SHALL select the mode: 00=10M, 01=100M, 10=1000M; 11 SHALL be treated as 1000M.
REQ-006 Ports rx_d_rise / rx_d_fall  in  4 each  SHALL be the rising- and falling-edge RXD nibbles from the DDR input buffer.
REQ-007 Ports rx_ctl_rise / rx_ctl_fall  in  1 each  SHALL be the rising- and falling-edge RX_CTL samples.
REQ-008 Ports gmii_rxd out 8, gmii_rx_dv out 1, gmii_rx_er out 1, gmii_rx_valid out 1 SHALL carry the assembled byte; the byte is valid only when gmii_rx_valid=1.
REQ-009 Ports link_up out 1, link_speed out 2, link_duplex out 1, status_change out 1 SHALL carry the filtered in-band status.
REQ-010 Ports align_err out 1 (pulse), align_err_count out ERR_COUNT_WIDTH SHALL report odd-nibble frames.

Function
REQ-011 Mode SHALL be latched from speed only in cycles where gmii_rx_dv would be 0; a speed change mid-frame SHALL take effect after the frame ends.
REQ-012 1000M: every cycle SHALL register gmii_rxd={rx_d_fall,rx_d_rise}, gmii_rx_dv=rx_ctl_rise, gmii_rx_er=rx_ctl_rise&(rx_ctl_rise^rx_ctl_fall), gmii_rx_valid=rx_ctl_rise; latency exactly 1 cycle.
REQ-013 10M/100M: only rx_d_rise SHALL be used; nibble FSM with states IDLE, LOW, HIGH.
REQ-014 IDLE->LOW when rx_ctl_rise=1: nibble stored as byte[3:0]; no output.
REQ-015 LOW->HIGH when rx_ctl_rise=1: nibble becomes byte[7:4]; next cycle gmii_rx_valid=1, gmii_rx_dv=1, gmii_rx_er=OR of the two nibbles' error flags (ctl_rise^ctl_fall).
REQ-016 HIGH->LOW when rx_ctl_rise=1, HIGH->IDLE when rx_ctl_rise=0.
REQ-017 LOW->IDLE when rx_ctl_rise=0: partial nibble SHALL be discarded, align_err pulses 1 cycle, align_err_count increments, saturating at all-ones.
REQ-018 10M/100M gmii_rx_dv SHALL stay 1 from first emitted byte until the cycle after the last; gmii_rx_valid SHALL pulse every second cycle.
REQ-019 An IFG cycle is rx_ctl_rise=0 and rx_ctl_fall=0; in it, sample S={rx_d_rise[3],rx_d_rise[2:1],rx_d_rise[0]} = {duplex,speed,link}.
REQ-020 Filter counter SHALL reset to 1 when S differs from the previous IFG sample, increment (saturating at STATUS_FILTER) when equal, and hold in non-IFG cycles.
REQ-021 When the counter reaches STATUS_FILTER, outputs SHALL load S; status_change SHALL pulse 1 cycle only if the loaded value differs from the previous outputs.
REQ-022 Carrier-sense/special symbols (ctl_rise=0, ctl_fall=1) SHALL neither produce bytes nor feed the status filter.

Reset
REQ-023 On rst_n=0 all outputs SHALL be 0, FSM IDLE, mode 1000M, filter counter 0, immediately and asynchronously; a frame in progress is dropped without align_err.
REQ-024 Reset deassertion SHALL be honoured on the next clk rising edge.

Configuration
REQ-025 Macro RGMII_INBAND_STATUS_EN defined: REQ-019..REQ-021 logic present.
REQ-026 Macro undefined: status logic SHALL be absent; link_up=1, link_speed=speed, link_duplex=1, status_change=0 constantly.

Verification
REQ-027 1000M, ctl=1/1, rise=5, fall=A for 3 cycles -> gmii_rxd=0xA5, dv=1, valid=1, er=0 one cycle later, 3 cycles.
REQ-028 100M, ctl_rise=1 for 4 cycles, rise 5,D,2,4 -> bytes 0xD5 then 0x42, valid pulsing alternate cycles, align_err=0.
REQ-029 100M, ctl_rise=1 for 3 cycles -> one byte, then align_err pulse, align_err_count=1; at all-ones count stays all-ones.
REQ-030 STATUS_FILTER=4, IFG rise=0xD for 3 cycles -> no change; 4th cycle -> link_up=1, link_speed=10, link_duplex=1, status_change pulse; glitch 0xC at cycle 2 restarts count.
REQ-031 rst_n low mid-frame in 10M LOW state -> all outputs 0 asynchronously, count unchanged-from-reset 0, no align_err; speed change 00->10 mid-frame applies only after dv falls.

Source files
------------

// File: rtl/rgmii_rx_mode_adapter.sv
// RGMII receive adapter: DDR nibbles to GMII bytes for 10/100/1000M, with alignment-error counting.
// Define RGMII_INBAND_STATUS_EN to enable the filtered in-band link status decoder.
module rgmii_rx_mode_adapter #(
    parameter int unsigned STATUS_FILTER   = 4,
    parameter int unsigned ERR_COUNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 speed,
    input  logic [3:0]                 rx_d_rise,
    input  logic [3:0]                 rx_d_fall,
    input  logic                       rx_ctl_rise,
    input  logic                       rx_ctl_fall,
    output logic [7:0]                 gmii_rxd,
    output logic                       gmii_rx_dv,
    output logic                       gmii_rx_er,
    output logic                       gmii_rx_valid,
    output logic                       link_up,
    output logic [1:0]                 link_speed,
    output logic                       link_duplex,
    output logic                       status_change,
    output logic                       align_err,
    output logic [ERR_COUNT_WIDTH-1:0] align_err_count
);

    typedef enum logic [1:0] {ST_IDLE, ST_LOW, ST_HIGH} nib_state_e;
    typedef enum logic [1:0] {MODE_10M = 2'b00, MODE_100M = 2'b01, MODE_1000M = 2'b10} mode_e;

    localparam logic [ERR_COUNT_WIDTH-1:0] CNT_ONE = {{(ERR_COUNT_WIDTH-1){1'b0}}, 1'b1};

    nib_state_e                 state_q, state_d;
    mode_e                      mode_q, mode_d;
    logic [3:0]                 low_nib_q, low_nib_d;
    logic                       low_err_q, low_err_d;
    logic [7:0]                 rxd_q, rxd_d;
    logic                       dv_q, dv_d;
    logic                       er_q, er_d;
    logic                       valid_q, valid_d;
    logic                       align_err_q, align_err_d;
    logic [ERR_COUNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic                       nib_err;

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        low_nib_d   = low_nib_q;
        low_err_d   = low_err_q;
        rxd_d       = rxd_q;
        dv_d        = 1'b0;
        er_d        = 1'b0;
        valid_d     = 1'b0;
        align_err_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        nib_err     = rx_ctl_rise ^ rx_ctl_fall;

        if (mode_q == MODE_1000M) begin
            state_d = ST_IDLE;
            rxd_d   = {rx_d_fall, rx_d_rise};
            dv_d    = rx_ctl_rise;
            er_d    = rx_ctl_rise & nib_err;
            valid_d = rx_ctl_rise;
        end else begin
            // dv holds across the LOW gap between bytes and drops once the frame ends
            dv_d = rx_ctl_rise && (state_q != ST_IDLE);
            unique case (state_q)
                ST_IDLE: begin
                    if (rx_ctl_rise) begin
                        state_d   = ST_LOW;
                        low_nib_d = rx_d_rise;
                        low_err_d = nib_err;
                    end
                end
                ST_LOW: begin
                    if (rx_ctl_rise) begin
                        state_d = ST_HIGH;
                        rxd_d   = {rx_d_rise, low_nib_q};
                        valid_d = 1'b1;
                        er_d    = low_err_q | nib_err;
                    end else begin
                        state_d     = ST_IDLE;
                        align_err_d = 1'b1;
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + CNT_ONE;
                        end
                    end
                end
                ST_HIGH: begin
                    if (rx_ctl_rise) begin
                        state_d   = ST_LOW;
                        low_nib_d = rx_d_rise;
                        low_err_d = nib_err;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Mode only follows speed between frames so a frame is never split across modes
        if ((state_d == ST_IDLE) && !dv_d) begin
            mode_d = (speed == 2'b00) ? MODE_10M :
                     (speed == 2'b01) ? MODE_100M : MODE_1000M;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_1000M;
            low_nib_q   <= '0;
            low_err_q   <= 1'b0;
            rxd_q       <= '0;
            dv_q        <= 1'b0;
            er_q        <= 1'b0;
            valid_q     <= 1'b0;
            align_err_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            low_nib_q   <= low_nib_d;
            low_err_q   <= low_err_d;
            rxd_q       <= rxd_d;
            dv_q        <= dv_d;
            er_q        <= er_d;
            valid_q     <= valid_d;
            align_err_q <= align_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign gmii_rxd        = rxd_q;
    assign gmii_rx_dv      = dv_q;
    assign gmii_rx_er      = er_q;
    assign gmii_rx_valid   = valid_q;
    assign align_err       = align_err_q;
    assign align_err_count = err_cnt_q;

`ifdef RGMII_INBAND_STATUS_EN
    localparam logic [7:0] FILT_MAX = 8'(STATUS_FILTER);

    logic [3:0] s_prev_q, s_prev_d;
    logic [3:0] status_q, status_d;
    logic [7:0] filt_cnt_q, filt_cnt_d;
    logic       change_q, change_d;
    logic       ifg;

    always_comb begin
        s_prev_d   = s_prev_q;
        status_d   = status_q;
        filt_cnt_d = filt_cnt_q;
        change_d   = 1'b0;
        ifg        = !rx_ctl_rise && !rx_ctl_fall;

        if (ifg) begin
            s_prev_d = rx_d_rise;
            if (rx_d_rise != s_prev_q) begin
                filt_cnt_d = 8'd1;
            end else if (filt_cnt_q != FILT_MAX) begin
                filt_cnt_d = filt_cnt_q + 8'd1;
            end
            if (filt_cnt_d == FILT_MAX) begin
                status_d = rx_d_rise;
                change_d = (rx_d_rise != status_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_prev_q   <= '0;
            status_q   <= '0;
            filt_cnt_q <= '0;
            change_q   <= 1'b0;
        end else begin
            s_prev_q   <= s_prev_d;
            status_q   <= status_d;
            filt_cnt_q <= filt_cnt_d;
            change_q   <= change_d;
        end
    end

    assign link_up       = status_q[0];
    assign link_speed    = status_q[2:1];
    assign link_duplex   = status_q[3];
    assign status_change = change_q;
`else
    assign link_up       = 1'b1;
    assign link_speed    = speed;
    assign link_duplex   = 1'b1;
    assign status_change = 1'b0;
`endif

endmodule

// File: tb/tb_rgmii_rx_mode_adapter.sv
// Scoreboard bench for rgmii_rx_mode_adapter: directed RGMII stimulus, byte monitor pops expected queue.
module tb_rgmii_rx_mode_adapter;

    localparam int unsigned CW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    speed;
    logic [3:0]    rx_d_rise, rx_d_fall;
    logic          rx_ctl_rise, rx_ctl_fall;
    logic [7:0]    gmii_rxd;
    logic          gmii_rx_dv, gmii_rx_er, gmii_rx_valid;
    logic          link_up, link_duplex, status_change, align_err;
    logic [1:0]    link_speed;
    logic [CW-1:0] align_err_count;

    int errors = 0;
    int checks = 0;
    logic [8:0] exp_q[$];

    rgmii_rx_mode_adapter #(.STATUS_FILTER(4), .ERR_COUNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .speed(speed),
        .rx_d_rise(rx_d_rise), .rx_d_fall(rx_d_fall),
        .rx_ctl_rise(rx_ctl_rise), .rx_ctl_fall(rx_ctl_fall),
        .gmii_rxd(gmii_rxd), .gmii_rx_dv(gmii_rx_dv), .gmii_rx_er(gmii_rx_er),
        .gmii_rx_valid(gmii_rx_valid), .link_up(link_up), .link_speed(link_speed),
        .link_duplex(link_duplex), .status_change(status_change),
        .align_err(align_err), .align_err_count(align_err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic cr, input logic cf, input logic [3:0] dr, input logic [3:0] df);
        rx_ctl_rise = cr;
        rx_ctl_fall = cf;
        rx_d_rise   = dr;
        rx_d_fall   = df;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 4'h0, 4'h0);
    endtask

    task automatic monitor();
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && gmii_rx_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got %0h expected no byte at %0t",
                             {gmii_rx_er, gmii_rxd}, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("byte_er_rxd", {23'd0, gmii_rx_er, gmii_rxd}, {23'd0, e});
                    chk("dv_with_valid", {31'd0, gmii_rx_dv}, 32'd1);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        speed = 2'b10;
        rx_ctl_rise = 1'b0; rx_ctl_fall = 1'b0; rx_d_rise = '0; rx_d_fall = '0;
        fork
            monitor();
        join_none

        #3;
        chk("rst_gmii", {20'd0, gmii_rxd, gmii_rx_dv, gmii_rx_er, gmii_rx_valid, align_err}, 32'd0);
        chk("rst_count", {29'd0, align_err_count}, 32'd0);
`ifdef RGMII_INBAND_STATUS_EN
        chk("rst_link", {27'd0, link_up, link_speed, link_duplex, status_change}, 32'd0);
`else
        chk("const_link", {27'd0, link_up, link_speed, link_duplex, status_change}, 32'b11010);
`endif
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(3);

        // 1000M: three clean bytes, one error byte, then a carrier symbol
        repeat (3) begin
            exp_q.push_back({1'b0, 8'hA5});
            drive(1'b1, 1'b1, 4'h5, 4'hA);
        end
        exp_q.push_back({1'b1, 8'h73});
        drive(1'b1, 1'b0, 4'h3, 4'h7);
        drive(1'b0, 1'b1, 4'h9, 4'h9);
        chk("carrier_no_dv", {31'd0, gmii_rx_dv}, 32'd0);
        idle(1);

        // 100M frame of two bytes
        speed = 2'b01;
        idle(2);
        exp_q.push_back({1'b0, 8'hD5});
        exp_q.push_back({1'b0, 8'h42});
        drive(1'b1, 1'b1, 4'h5, 4'h0);
        drive(1'b1, 1'b1, 4'hD, 4'h0);
        drive(1'b1, 1'b1, 4'h2, 4'h0);
        chk("dv_gap", {30'd0, gmii_rx_dv, gmii_rx_valid}, 32'b10);
        drive(1'b1, 1'b1, 4'h4, 4'h0);
        drive(1'b0, 1'b0, 4'h0, 4'h0);
        chk("dv_end", {30'd0, gmii_rx_dv, align_err}, 32'd0);
        chk("count_clean", {29'd0, align_err_count}, 32'd0);
        exp_q.push_back({1'b1, 8'h81});
        drive(1'b1, 1'b0, 4'h1, 4'h0);
        drive(1'b1, 1'b1, 4'h8, 4'h0);
        idle(1);

        // odd-nibble frames and counter saturation
        exp_q.push_back({1'b0, 8'h37});
        drive(1'b1, 1'b1, 4'h7, 4'h0);
        drive(1'b1, 1'b1, 4'h3, 4'h0);
        drive(1'b1, 1'b1, 4'h9, 4'h0);
        drive(1'b0, 1'b0, 4'h0, 4'h0);
        chk("align_pulse", {31'd0, align_err}, 32'd1);
        chk("align_count1", {29'd0, align_err_count}, 32'd1);
        idle(1);
        chk("align_pulse_end", {31'd0, align_err}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, 4'(i), 4'h0);
            drive(1'b0, 1'b0, 4'h0, 4'h0);
        end
        chk("align_count7", {29'd0, align_err_count}, 32'd7);
        drive(1'b1, 1'b1, 4'hE, 4'h0);
        drive(1'b0, 1'b0, 4'h0, 4'h0);
        chk("align_sat", {28'd0, align_err, align_err_count}, 32'hF);
        idle(1);

        // 10M frame with speed moved to 1000M mid-frame
        speed = 2'b00;
        idle(2);
        exp_q.push_back({1'b0, 8'h16});
        exp_q.push_back({1'b0, 8'h32});
        drive(1'b1, 1'b1, 4'h6, 4'hF);
        speed = 2'b10;
        drive(1'b1, 1'b1, 4'h1, 4'hF);
        drive(1'b1, 1'b1, 4'h2, 4'hF);
        drive(1'b1, 1'b1, 4'h3, 4'hF);
        drive(1'b0, 1'b0, 4'h0, 4'h0);
        chk("mode_dv_fall", {31'd0, gmii_rx_dv}, 32'd0);
        exp_q.push_back({1'b0, 8'hBE});
        drive(1'b1, 1'b1, 4'hE, 4'hB);
        idle(1);

        // asynchronous reset in the middle of a 10M frame
        speed = 2'b00;
        idle(1);
        exp_q.push_back({1'b0, 8'hD5});
        drive(1'b1, 1'b1, 4'h5, 4'h0);
        drive(1'b1, 1'b1, 4'hD, 4'h0);
        drive(1'b1, 1'b1, 4'h2, 4'h0);
        rst_n = 1'b0;
        #2;
        chk("async_rst_gmii", {20'd0, gmii_rxd, gmii_rx_dv, gmii_rx_er, gmii_rx_valid, align_err}, 32'd0);
        chk("async_rst_count", {29'd0, align_err_count}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.push_back({1'b0, 8'h21});
        drive(1'b1, 1'b1, 4'h1, 4'h2);
        drive(1'b0, 1'b0, 4'h0, 4'h0);
        chk("rst_no_align", {28'd0, align_err, align_err_count}, 32'd0);
        idle(2);

`ifdef RGMII_INBAND_STATUS_EN
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 4'hD, 4'h0);
            chk("status_hold", {30'd0, link_up, status_change}, 32'd0);
        end
        drive(1'b0, 1'b0, 4'hD, 4'h0);
        chk("status_load", {27'd0, link_up, link_speed, link_duplex, status_change}, 32'b11011);
        drive(1'b0, 1'b0, 4'hD, 4'h0);
        chk("status_pulse_end", {27'd0, link_up, link_speed, link_duplex, status_change}, 32'b11010);
        drive(1'b0, 1'b0, 4'h3, 4'h0);
        drive(1'b0, 1'b0, 4'hC, 4'h0);
        drive(1'b0, 1'b0, 4'h3, 4'h0);
        drive(1'b0, 1'b0, 4'h3, 4'h0);
        drive(1'b0, 1'b0, 4'h3, 4'h0);
        chk("glitch_restart", {27'd0, link_up, link_speed, link_duplex, status_change}, 32'b11010);
        drive(1'b0, 1'b1, 4'h3, 4'h0);
        chk("carrier_no_filter", {27'd0, link_up, link_speed, link_duplex, status_change}, 32'b11010);
        drive(1'b0, 1'b0, 4'h3, 4'h0);
        chk("status_load2", {27'd0, link_up, link_speed, link_duplex, status_change}, 32'b10101);
`else
        chk("const_link_10", {27'd0, link_up, link_speed, link_duplex, status_change}, 32'b10010);
        speed = 2'b01;
        #1;
        chk("const_link_100", {27'd0, link_up, link_speed, link_duplex, status_change}, 32'b10110);
`endif

        idle(3);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
